// File: rtl/veripac9_port_arb.sv
// Arbitrates the VeriPac-9 memory port between host DATA accesses and a FIFO-fed burst engine.
// Optional build macro VERIPAC9_ARB_AUTOINC_EN: host pointer post-increments on DATA accesses.
module veripac9_port_arb #(
  parameter logic [7:0]  ZXUNO_DATA_REG  = 8'hFA,
  parameter logic [7:0]  ZXUNO_ADDR_REG  = 8'hFB,
  parameter logic [7:0]  ZXUNO_BURST_REG = 8'hFC,
  parameter logic [7:0]  ZXUNO_CTRL_REG  = 8'hFD,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe_n,
  output logic [7:0] vp_addr,
  output logic       vp_rd,
  output logic       vp_wr,
  output logic [7:0] vp_din,
  input  logic [7:0] vp_dout
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  DEPTH_L = 4'(FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t          state_q, state_d;
  logic [7:0]      ptr_q, ptr_d, bptr_q, bptr_d;
  logic [7:0]      acc_rem_q, acc_rem_d, wr_rem_q, wr_rem_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [3:0]      level_q, level_d;
  logic            done_q, done_d, ovf_q, ovf_d;
  logic            pend_q, pend_d;
  logic [7:0]      pend_addr_q, pend_addr_d, pend_data_q, pend_data_d;
  logic [7:0]      fifo_q [FIFO_DEPTH];

  logic data_rd, data_wr, addr_rd, addr_wr, ctrl_rd, ctrl_wr, burst_wr;
  logic push, pend_beat, eng_beat;

  assign data_rd  = zxuno_regrd && (zxuno_addr == ZXUNO_DATA_REG);
  assign data_wr  = zxuno_regwr && (zxuno_addr == ZXUNO_DATA_REG);
  assign addr_rd  = zxuno_regrd && (zxuno_addr == ZXUNO_ADDR_REG);
  assign addr_wr  = zxuno_regwr && (zxuno_addr == ZXUNO_ADDR_REG);
  assign ctrl_rd  = zxuno_regrd && (zxuno_addr == ZXUNO_CTRL_REG);
  assign ctrl_wr  = zxuno_regwr && (zxuno_addr == ZXUNO_CTRL_REG);
  assign burst_wr = zxuno_regwr && (zxuno_addr == ZXUNO_BURST_REG);

  assign push = burst_wr && (state_q == ST_RUN) && (level_q != DEPTH_L) && (acc_rem_q != 8'd0);

  // Port mux: host read, then pending host write, then engine; an engine beat is
  // withheld during a CTRL write so an abort/restart takes effect in its own cycle.
  always_comb begin
    vp_rd     = 1'b0;
    vp_wr     = 1'b0;
    vp_addr   = '0;
    vp_din    = '0;
    pend_beat = 1'b0;
    eng_beat  = 1'b0;
    if (data_rd) begin
      vp_rd   = 1'b1;
      vp_addr = ptr_q;
    end else if (pend_q) begin
      vp_wr     = 1'b1;
      vp_addr   = pend_addr_q;
      vp_din    = pend_data_q;
      pend_beat = 1'b1;
    end else if ((state_q == ST_RUN) && (level_q != 4'd0) && !ctrl_wr) begin
      vp_wr    = 1'b1;
      vp_addr  = bptr_q;
      vp_din   = fifo_q[rd_ptr_q];
      eng_beat = 1'b1;
    end
  end

  always_comb begin
    dout = '0;
    oe_n = 1'b1;
    if (data_rd) begin
      dout = vp_dout;
      oe_n = 1'b0;
    end else if (addr_rd) begin
      dout = ptr_q;
      oe_n = 1'b0;
    end else if (ctrl_rd) begin
      dout = {state_q == ST_RUN, done_q, ovf_q, 2'b00, level_q[2:0]};
      oe_n = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    bptr_d      = bptr_q;
    acc_rem_d   = acc_rem_q;
    wr_rem_d    = wr_rem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    level_d     = level_q;
    done_d      = done_q;
    ovf_d       = ovf_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;

    if (ctrl_rd) begin
      done_d = 1'b0;
      ovf_d  = 1'b0;
    end
    if (burst_wr && !push) ovf_d = 1'b1;

    if (addr_wr) ptr_d = din;
`ifdef VERIPAC9_ARB_AUTOINC_EN
    if (data_rd || data_wr) ptr_d = ptr_q + 8'd1;
`endif

    if (pend_beat) pend_d = 1'b0;
    if (data_wr) begin
      pend_d      = 1'b1;
      pend_addr_d = ptr_q;
      pend_data_d = din;
    end

    if (push) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      acc_rem_d = acc_rem_q - 8'd1;
    end
    if (eng_beat) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      bptr_d   = bptr_q + 8'd1;
      wr_rem_d = wr_rem_q - 8'd1;
      if (wr_rem_q == 8'd1) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
    if (push && !eng_beat) level_d = level_q + 4'd1;
    else if (eng_beat && !push) level_d = level_q - 4'd1;

    if (ctrl_wr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
      if (din == 8'd0) begin
        state_d = ST_IDLE;
      end else begin
        state_d   = ST_RUN;
        bptr_d    = ptr_q;
        acc_rem_d = din;
        wr_rem_d  = din;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      bptr_q      <= '0;
      acc_rem_q   <= '0;
      wr_rem_q    <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      bptr_q      <= bptr_d;
      acc_rem_q   <= acc_rem_d;
      wr_rem_q    <= wr_rem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= din;
  end

endmodule
